// File: rtl/linebuff_win_ctrl.sv
// linebuff_win_ctrl: raster-stream sequencer that drives the line buffer shift enable and flags complete KERNEL x KERNEL windows
module linebuff_win_ctrl #(
    parameter int IMG_COLS = 32,
    parameter int IMG_ROWS = 32,
    parameter int KERNEL   = 5,
    localparam int CW = $clog2(IMG_COLS),
    localparam int RW = $clog2(IMG_ROWS)
) (
    input  logic          lb_clk,
    input  logic          lb_rst_b,
    input  logic          start_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    output logic          lb_en_o,
    output logic          win_valid_o,
    input  logic          win_ready_i,
    output logic [RW-1:0] win_row_o,
    output logic [CW-1:0] win_col_o,
    output logic          busy_o,
    output logic          frame_done_o
);
    if (KERNEL > IMG_COLS || KERNEL > IMG_ROWS) begin : g_bad_kernel
        $error("linebuff_win_ctrl: KERNEL exceeds image dimensions");
    end

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} state_t;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_COLS - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_ROWS - 1);
    localparam logic [CW-1:0] COL_K    = CW'(KERNEL - 1);
    localparam logic [RW-1:0] ROW_K    = RW'(KERNEL - 1);

    state_t        state;
    logic [RW-1:0] row;
    logic [CW-1:0] col;

    // A presented window that is not being consumed freezes the stream so the taps stay aligned with it
    assign in_ready_o = (state == STREAM) && !(win_valid_o && !win_ready_i);
    assign lb_en_o    = in_valid_i && in_ready_o;
    assign busy_o     = (state != IDLE);

    always_ff @(posedge lb_clk or negedge lb_rst_b) begin
        if (!lb_rst_b) begin
            state        <= IDLE;
            row          <= '0;
            col          <= '0;
            win_valid_o  <= 1'b0;
            win_row_o    <= '0;
            win_col_o    <= '0;
            frame_done_o <= 1'b0;
        end else begin
            frame_done_o <= 1'b0;
            case (state)
                IDLE: if (start_i) state <= STREAM;
                STREAM: begin
                    if (lb_en_o) begin
                        if (col == COL_LAST) begin
                            col <= '0;
                            if (row == ROW_LAST) begin
                                row   <= '0;
                                state <= FLUSH;
                            end else begin
                                row <= row + RW'(1);
                            end
                        end else begin
                            col <= col + CW'(1);
                        end
                    end
                end
                FLUSH: begin
                    if (!win_valid_o || win_ready_i) begin
                        state        <= DONE;
                        frame_done_o <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
            // Left-edge columns never qualify, so a window cannot straddle the row wrap
            if (lb_en_o && row >= ROW_K && col >= COL_K) begin
                win_valid_o <= 1'b1;
                win_row_o   <= row - ROW_K;
                win_col_o   <= col - COL_K;
            end else if (win_ready_i) begin
                win_valid_o <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_linebuff_win_ctrl.sv
// tb_linebuff_win_ctrl: directed bench for the line buffer window sequencer at default parameters
module tb_linebuff_win_ctrl;
    logic       lb_clk = 1'b0;
    logic       lb_rst_b = 1'b0;
    logic       start_i = 1'b0;
    logic       in_valid_i = 1'b0;
    logic       win_ready_i = 1'b1;
    logic       in_ready_o, lb_en_o, win_valid_o, busy_o, frame_done_o;
    logic [4:0] win_row_o, win_col_o;

    int n_pass = 0, n_chk = 0;
    int acc_cnt = 0, win_cnt = 0, done_cnt = 0, exp_r = 0, exp_c = 0;
    int cyc = 0, first_win_acc = -1, last_acc_cyc = 0, done_cyc = 0;
    bit seen_win = 1'b0;

    always #5 lb_clk = ~lb_clk;

    linebuff_win_ctrl dut (
        .lb_clk      (lb_clk),
        .lb_rst_b    (lb_rst_b),
        .start_i     (start_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .lb_en_o     (lb_en_o),
        .win_valid_o (win_valid_o),
        .win_ready_i (win_ready_i),
        .win_row_o   (win_row_o),
        .win_col_o   (win_col_o),
        .busy_o      (busy_o),
        .frame_done_o(frame_done_o)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge lb_clk);
        #1;
    endtask

    task automatic clear_mon;
        acc_cnt = 0;
        win_cnt = 0;
        done_cnt = 0;
        exp_r = 0;
        exp_c = 0;
        seen_win = 1'b0;
        first_win_acc = -1;
    endtask

    task automatic start_frame;
        clear_mon();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("start_busy", int'(busy_o), 1);
    endtask

    task automatic wait_acc(input int n);
        for (int i = 0; i < 40000 && acc_cnt != n; i++) #1;
        if (acc_cnt != n) begin
            $display("FAIL wait_acc: got %0d expected %0d", acc_cnt, n);
            $fatal(1, "accept count never reached");
        end
    endtask

    task automatic wait_done;
        for (int i = 0; i < 8000 && done_cnt == 0; i++) tick();
        check("done_seen", int'(done_cnt > 0), 1);
    endtask

    task automatic check_frame;
        check("win_cnt", win_cnt, 784);
        check("acc_cnt", acc_cnt, 1024);
        check("done_cnt", done_cnt, 1);
        check("busy_end", int'(busy_o), 0);
    endtask

    // Scoreboard: consumed windows must come out in raster order (0,0)..(27,27)
    always @(negedge lb_clk) begin
        cyc++;
        if (win_valid_o && !seen_win) begin
            seen_win = 1'b1;
            first_win_acc = acc_cnt;
        end
        if (lb_en_o) begin
            acc_cnt++;
            if (acc_cnt == 1024) last_acc_cyc = cyc;
        end
        if (win_valid_o && win_ready_i) begin
            check("win_seq", int'(win_row_o) * 32 + int'(win_col_o), exp_r * 32 + exp_c);
            win_cnt++;
            exp_c++;
            if (exp_c == 28) begin
                exp_c = 0;
                exp_r++;
            end
        end
        if (frame_done_o) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    initial begin
        int gap;
        gap = 0;
        in_valid_i = 1'b1;
        #12;
        check("rst_in_ready", int'(in_ready_o), 0);
        check("rst_lb_en", int'(lb_en_o), 0);
        check("rst_busy", int'(busy_o), 0);
        check("rst_win_valid", int'(win_valid_o), 0);
        check("rst_win_pos", int'(win_row_o) * 32 + int'(win_col_o), 0);
        check("rst_frame_done", int'(frame_done_o), 0);
        tick();
        lb_rst_b = 1'b1;
        tick();
        check("idle_busy", int'(busy_o), 0);

        // Frame 1: free-running stream
        start_frame();
        wait_done();
        check("first_win_acc", first_win_acc, 133);
        check("done_latency", done_cyc - last_acc_cyc, 2);
        repeat (2) tick();
        check_frame();
        check("last_win_row", int'(win_row_o), 27);
        check("last_win_col", int'(win_col_o), 27);

        // Frame 2: row edge, backpressure, start_i ignored outside IDLE
        start_frame();
        wait_acc(161);
        for (int c = 0; c < 4; c++) begin
            tick();
            check("edge_no_win", int'(win_valid_o), 0);
        end
        tick();
        check("edge_win_valid", int'(win_valid_o), 1);
        check("edge_win_pos", int'(win_row_o) * 32 + int'(win_col_o), 1 * 32 + 0);
        wait_acc(239);
        tick();
        check("stall_win_valid", int'(win_valid_o), 1);
        win_ready_i = 1'b0;
        start_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #2;
            check("stall_in_ready", int'(in_ready_o), 0);
            check("stall_lb_en", int'(lb_en_o), 0);
            check("stall_win_pos", int'(win_row_o) * 32 + int'(win_col_o), 3 * 32 + 10);
            start_i = 1'b0;
            tick();
        end
        win_ready_i = 1'b1;
        tick();
        check("resume_win_valid", int'(win_valid_o), 1);
        check("resume_win_pos", int'(win_row_o) * 32 + int'(win_col_o), 3 * 32 + 11);
        wait_acc(1024);
        tick();
        win_ready_i = 1'b0;
        start_i = 1'b1;
        tick();
        check("flush_busy", int'(busy_o), 1);
        check("flush_win_valid", int'(win_valid_o), 1);
        check("flush_win_pos", int'(win_row_o) * 32 + int'(win_col_o), 27 * 32 + 27);
        check("flush_no_done", int'(frame_done_o), 0);
        start_i = 1'b0;
        win_ready_i = 1'b1;
        tick();
        check("done_pulse", int'(frame_done_o), 1);
        check("done_busy", int'(busy_o), 1);
        start_i = 1'b1;
        tick();
        check("idle_after_done", int'(busy_o), 0);
        check("done_cleared", int'(frame_done_o), 0);
        check_frame();
        clear_mon();
        tick();
        check("idle_start_busy", int'(busy_o), 1);
        start_i = 1'b0;

        // Frame 3: bubbles on the input stream
        for (int i = 0; i < 8000 && done_cnt == 0; i++) begin
            if (gap > 0) begin
                in_valid_i = 1'b0;
                gap--;
            end else begin
                in_valid_i = 1'b1;
                gap = $urandom_range(0, 3);
            end
            tick();
        end
        in_valid_i = 1'b1;
        check("bubble_done", int'(done_cnt > 0), 1);
        tick();
        check_frame();

        // Frame 4: asynchronous reset at pixel 50 aborts, then a clean restart
        start_frame();
        wait_acc(50);
        lb_rst_b = 1'b0;
        #1;
        check("abort_in_ready", int'(in_ready_o), 0);
        check("abort_lb_en", int'(lb_en_o), 0);
        check("abort_busy", int'(busy_o), 0);
        check("abort_win_valid", int'(win_valid_o), 0);
        check("abort_frame_done", int'(frame_done_o), 0);
        repeat (2) tick();
        lb_rst_b = 1'b1;
        tick();
        check("abort_idle", int'(busy_o), 0);
        check("abort_no_done", done_cnt, 0);
        start_frame();
        wait_done();
        check("restart_first_win", first_win_acc, 133);
        repeat (2) tick();
        check_frame();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
